// File: rtl/zet_mem_pkg.sv
// Shared types and constants for the Wishbone-to-memory bridge.
// State encoding, byte-lane select codes and the wait-counter sizing helper.
package zet_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_ACK    = 2'd2
   } state_t;

   localparam logic [1:0] SEL_NONE = 2'b00;
   localparam logic [1:0] SEL_LO   = 2'b01;
   localparam logic [1:0] SEL_HI   = 2'b10;
   localparam logic [1:0] SEL_WORD = 2'b11;

   // Counter must hold WAIT_STATES itself; never narrower than one bit.
   function automatic int cnt_width(input int ws);
      return (ws < 2) ? 1 : $clog2(ws + 1);
   endfunction

endpackage

// File: rtl/memory_wb_bridge_if.sv
// Bus bundle between a Wishbone master, the bridge and a 16-bit memory port.
// Handshake: a request is presented by holding wb_cyc_i & wb_stb_i high; it completes on the single cycle wb_ack_o is high.
interface memory_wb_bridge_if;
   logic [18:0] wb_adr_i;
   logic [15:0] wb_dat_i;
   logic [1:0]  wb_sel_i;
   logic        wb_we_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic [15:0] wb_dat_o;
   logic        wb_ack_o;

   logic [19:0] mem_addr;
   logic [15:0] mem_wr_data;
   logic [15:0] mem_rd_data;
   logic        mem_we_n;
   logic        mem_byte;

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
      output wb_dat_o, wb_ack_o,
      output mem_addr, mem_wr_data, mem_we_n, mem_byte,
      input  mem_rd_data
   );

   modport master (
      output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
      input  wb_dat_o, wb_ack_o
   );

   modport memory (
      input  mem_addr, mem_wr_data, mem_we_n, mem_byte,
      output mem_rd_data
   );
endinterface

// File: rtl/memory_wb_bridge.sv
// Wishbone slave bridging 16-bit word/byte accesses onto a byte-addressed memory port,
// with a programmable number of wait states before acknowledge.
module memory_wb_bridge
   import zet_mem_pkg::*;
#(
   parameter int WAIT_STATES = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   memory_wb_bridge_if.slave   bus,
   output state_t              dbg_state
);

   localparam int             CW       = cnt_width(WAIT_STATES);
   localparam logic [CW-1:0]  CNT_LOAD = CW'(WAIT_STATES);

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic           ack, ack_nxt;
   logic [15:0]    dat_o, dat_nxt;
   logic           latch;

   logic [18:0]    adr_q;
   logic [15:0]    dat_q;
   logic [1:0]     sel_q;
   logic           we_q;

   logic [15:0]    rd_lane;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         ack   <= 1'b0;
         dat_o <= '0;
         adr_q <= '0;
         dat_q <= '0;
         sel_q <= SEL_NONE;
         we_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         ack   <= ack_nxt;
         dat_o <= dat_nxt;
         if (latch) begin
            adr_q <= bus.wb_adr_i;
            dat_q <= bus.wb_dat_i;
            sel_q <= bus.wb_sel_i;
            we_q  <= bus.wb_we_i;
         end
      end
   end

   // Dropping wb_cyc_i aborts; wb_stb_i only matters for starting a request.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ack_nxt   = 1'b0;
      dat_nxt   = dat_o;
      latch     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.wb_cyc_i && bus.wb_stb_i && !ack) begin
               state_nxt = ST_ACCESS;
               cnt_nxt   = CNT_LOAD;
               latch     = 1'b1;
            end
         end
         ST_ACCESS: begin
            if (!bus.wb_cyc_i) begin
               state_nxt = ST_IDLE;
            end else if (cnt == '0) begin
               state_nxt = ST_ACK;
               ack_nxt   = 1'b1;
               dat_nxt   = rd_lane;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         ST_ACK: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Byte reads come back in the low lane; the memory's upper byte is a sign extension.
   always_comb begin
      rd_lane = '0;
      case (sel_q)
         SEL_WORD: rd_lane = bus.mem_rd_data;
         SEL_LO:   rd_lane = {8'h00, bus.mem_rd_data[7:0]};
         SEL_HI:   rd_lane = {bus.mem_rd_data[7:0], 8'h00};
         default:  rd_lane = '0;
      endcase
   end

   always_comb begin
      bus.mem_addr    = {adr_q, 1'b0};
      bus.mem_wr_data = dat_q;
      bus.mem_byte    = 1'b0;
      case (sel_q)
         SEL_LO: begin
            bus.mem_byte = 1'b1;
         end
         SEL_HI: begin
            bus.mem_addr    = {adr_q, 1'b1};
            bus.mem_wr_data = {dat_q[15:8], dat_q[15:8]};
            bus.mem_byte    = 1'b1;
         end
         default: begin
            bus.mem_byte = 1'b0;
         end
      endcase
   end

   // rst_n in the term kills a pending strobe at once, not at the next edge.
   assign bus.mem_we_n = !(rst_n && (state == ST_ACCESS) && (cnt == '0) && we_q &&
                           (sel_q != SEL_NONE) && bus.wb_cyc_i);

   assign bus.wb_ack_o = ack;
   assign bus.wb_dat_o = dat_o;
   assign dbg_state    = state;

endmodule
